// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus bundle: incrementer, redirect/hazard controls,
// instruction memory handshake and the IF/ID register outputs.
interface fetch_pc_ctrl_if;
  logic [15:0] inc_pc;
  logic [15:0] curr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        halted;

  // Fetch controller side
  modport master (
    input  inc_pc, redirect, redirect_pc, stall, halt, imem_ready, imem_data,
    output curr_pc, imem_req, if_valid, if_instr, if_pc_inc, halted
  );

  // Core / memory side
  modport slave (
    output inc_pc, redirect, redirect_pc, stall, halt, imem_ready, imem_data,
    input  curr_pc, imem_req, if_valid, if_instr, if_pc_inc, halted
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register and instruction-fetch controller. Owns the fetch PC,
// the one-entry skid buffer used while decode is stalled, and the IF/ID
// register. Redirects and HALT that arrive while a memory request is still
// waiting are parked in FLUSH until the request completes, because the
// memory requires address and request to stay stable until accepted.
module fetch_pc_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_ctrl_if.master  fetch
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_pending_pc;
  logic        r_halt_pending;
  logic        r_buf_valid;
  logic [15:0] r_buf_instr;
  logic [15:0] r_buf_pc_inc;
  logic        r_if_valid;
  logic [15:0] r_if_instr;
  logic [15:0] r_if_pc_inc;

  logic        w_req;
  logic        w_accept;
  logic        w_wait;

  // Request decode from registered state; the skid buffer blocks new
  // fetches so it can never be overwritten.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_FETCH: w_req = ~r_buf_valid;
      ST_FLUSH: w_req = 1'b1;
      ST_HALT:  w_req = 1'b0;
      default:  w_req = 1'b0;
    endcase
  end

  assign w_accept = w_req & fetch.imem_ready;
  assign w_wait   = w_req & ~fetch.imem_ready;

  // Fetch FSM, PC, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_FETCH;
      r_pc           <= RESET_PC;
      r_pending_pc   <= 16'h0000;
      r_halt_pending <= 1'b0;
      r_buf_valid    <= 1'b0;
      r_buf_instr    <= 16'h0000;
      r_buf_pc_inc   <= 16'h0000;
      r_if_valid     <= 1'b0;
      r_if_instr     <= NOP_INSTR;
      r_if_pc_inc    <= 16'h0000;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (fetch.redirect) begin
            // Squash everything in flight; any word accepted now is wrong-path.
            r_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
            if (w_wait) begin
              r_pending_pc   <= fetch.redirect_pc;
              r_halt_pending <= 1'b0;
              r_state        <= ST_FLUSH;
            end else begin
              r_pc    <= fetch.redirect_pc;
              r_state <= ST_FETCH;
            end
          end else if (fetch.stall) begin
            // IF/ID frozen; a word arriving now goes into the skid buffer.
            if (w_accept) begin
              r_pc         <= fetch.inc_pc;
              r_buf_valid  <= 1'b1;
              r_buf_instr  <= fetch.imem_data;
              r_buf_pc_inc <= fetch.inc_pc;
            end else begin
              r_pc <= r_pc;
            end
          end else if (fetch.halt) begin
            r_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
            if (w_wait) begin
              r_halt_pending <= 1'b1;
              r_state        <= ST_FLUSH;
            end else begin
              r_state <= ST_HALT;
            end
          end else if (r_buf_valid) begin
            // Drain the skid buffer before fetching again.
            r_if_valid  <= 1'b1;
            r_if_instr  <= r_buf_instr;
            r_if_pc_inc <= r_buf_pc_inc;
            r_buf_valid <= 1'b0;
          end else if (w_accept) begin
            r_pc        <= fetch.inc_pc;
            r_if_valid  <= 1'b1;
            r_if_instr  <= fetch.imem_data;
            r_if_pc_inc <= fetch.inc_pc;
          end else begin
            r_if_valid <= 1'b0;
          end
        end

        ST_FLUSH: begin
          if (fetch.redirect) begin
            r_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
            if (w_wait) begin
              r_pending_pc   <= fetch.redirect_pc;
              r_halt_pending <= 1'b0;
              r_state        <= ST_FLUSH;
            end else begin
              r_pc    <= fetch.redirect_pc;
              r_state <= ST_FETCH;
            end
          end else if (w_accept) begin
            // The stale word completes the handshake and is dropped.
            if (r_halt_pending) begin
              r_state <= ST_HALT;
            end else begin
              r_pc    <= r_pending_pc;
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_FLUSH;
          end
        end

        ST_HALT: begin
          r_state <= ST_HALT;
        end

        default: begin
          r_state    <= ST_FETCH;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.curr_pc   = r_pc;
  assign fetch.imem_req  = w_req & ~rst;
  assign fetch.if_valid  = r_if_valid;
  assign fetch.if_instr  = r_if_instr;
  assign fetch.if_pc_inc = r_if_pc_inc;
  assign fetch.halted    = (r_state == ST_HALT);

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage PC register and instruction-fetch controller for the 16-bit pipelined core. Holds the architectural fetch PC, drives it to instruction memory and to the PC incrementer, and loads the incrementer's PC+2 result back each accepted fetch. Handles branch/jump redirects, hazard stalls through a one-entry skid buffer, and HALT. Produces the IF/ID pipeline register contents.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, instruction placed in if_instr on reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inc_pc  in  16  curr_pc + 2 from the PC incrementer
- curr_pc  out  16  registered fetch PC (imem address, incrementer input)
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  16  redirect target
- stall  in  1  hazard unit: hold IF/ID and PC
- halt  in  1  decode: instruction in IF/ID is HALT
- imem_req  out  1  fetch request at address curr_pc
- imem_ready  in  1  memory returns imem_data this cycle
- imem_data  in  16  fetched instruction
- if_valid  out  1  IF/ID holds a live instruction
- if_instr  out  16  IF/ID instruction
- if_pc_inc  out  16  IF/ID PC+2 (return address / branch base)
- halted  out  1  core halted

## Operation
- Accept = imem_req & imem_ready. Once imem_req rises, it and curr_pc stay stable until accept (memory contract).
- States: FETCH, FLUSH, HALT. Registers: pc, pending_pc, halt_pending, skid {buf_valid, buf_instr, buf_pc_inc}, IF/ID {if_valid, if_instr, if_pc_inc}.
- imem_req: FETCH -> !buf_valid; FLUSH -> 1; HALT -> 0.
- FETCH, accept: pc <= inc_pc. If stall=0, IF/ID <= {1, imem_data, inc_pc}; if stall=1, skid <= {1, imem_data, inc_pc}, IF/ID held.
- FETCH, buf_valid=1, stall=0: IF/ID <= {1, buf_instr, buf_pc_inc}; buf_valid <= 0.
- FETCH, no accept, buf empty, stall=0: if_valid <= 0 (bubble).
- stall=1 (no redirect): IF/ID and pc held except pc update on accept as above.
- Redirect (FETCH or FLUSH; highest priority; overrides stall and halt): if_valid <= 0, buf_valid <= 0, data accepted this cycle discarded. If imem_req & !imem_ready: pending_pc <= redirect_pc, halt_pending <= 0, state <= FLUSH. Otherwise pc <= redirect_pc, state <= FETCH.
- halt (FETCH, redirect=0, stall=0): if_valid <= 0, buf_valid <= 0. If imem_req & !imem_ready: halt_pending <= 1, state <= FLUSH; else state <= HALT.
- FLUSH, accept, no redirect: data discarded; halt_pending ? state <= HALT : (pc <= pending_pc, state <= FETCH).
- HALT: all registers hold, imem_req=0, if_valid=0; exit only by rst.
- halted = (state == HALT).
- PC arithmetic is 16-bit, wraps modulo 2^16 (0xFFFE + 2 -> 0x0000); no checks.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=NOP_INSTR, if_pc_inc=0, buf_valid=0, halt_pending=0, pending_pc=0; imem_req=0 while rst high, 1 in first cycle after deassertion.
- Reset mid-request or in FLUSH/HALT: all state dropped, no memory handshake honoured.
- Accept in cycle N -> if_valid=1 with that instruction at N+1; curr_pc advances at N+1.
- Redirect in cycle N with no outstanding wait -> curr_pc=redirect_pc at N+1, if_valid=0 at N+1.
- Redirect during an unaccepted request -> curr_pc held until accept in cycle M, curr_pc=target at M+1.
- Skid never overflows: imem_req low while buf_valid=1.
- Zero-wait memory (imem_ready tied high), no stall: one instruction per cycle.

## Test plan
- Reset then imem_ready=1, data 0x1111,0x2222: curr_pc 0x0000,0x0002,0x0004; if_instr 0x1111 then 0x2222, if_pc_inc 0x0002 then 0x0004.
- Stall one cycle as data 0xAAAA accepted: IF/ID holds prior value, skid captures 0xAAAA, imem_req=0 next cycle, 0xAAAA appears when stall drops; no instruction lost or duplicated.
- Redirect to 0x0100 with imem_ready=1: next curr_pc=0x0100, if_valid=0 one cycle, fetched word discarded.
- Redirect to 0x0200 while imem_ready=0 for 3 cycles: curr_pc stays old, imem_req high; after accept, returned data discarded and curr_pc=0x0200.
- halt with stall=0: halted=1 next cycle, imem_req=0, curr_pc frozen; simultaneous redirect+halt -> redirect taken, halted=0.
- pc=0xFFFE fetch accepted: curr_pc wraps to 0x0000; async rst mid-FLUSH -> curr_pc=RESET_PC, if_valid=0 immediately.
